// File: rtl/digital_tube_ctrl_pkg.sv
// Shared definitions for the seven-segment tube controller: register map,
// CTRL field layout, segment code table and the byte-merge helper.
package digital_tube_ctrl_pkg;

  localparam logic DATA_ADDR = 1'b0;
  localparam logic CTRL_ADDR = 1'b1;

  localparam int unsigned CTRL_VAL_LSB = 0;
  localparam int unsigned CTRL_VAL_MSB = 3;
  localparam int unsigned CTRL_EN_BIT  = 4;
  localparam int unsigned CTRL_W       = 5;
  localparam logic [CTRL_W-1:0] CTRL_RESET = 5'h10;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] SEL_OFF   = 4'hF;

  // Active-low segment codes, dp off; entry i is the glyph for hex digit i.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef struct packed {
    logic [7:0] seg0;
    logic [3:0] sel0;
    logic [7:0] seg1;
    logic [3:0] sel1;
    logic [7:0] seg2;
    logic       sel2;
  } tube_out_t;

  localparam tube_out_t TUBE_OUT_BLANK = '{
    seg0: SEG_BLANK, sel0: SEL_OFF,
    seg1: SEG_BLANK, sel1: SEL_OFF,
    seg2: SEG_BLANK, sel2: 1'b1
  };

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] digit_sel_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/digital_tube_ctrl_hex_to_seg.sv
// Combinational hex digit to active-low seven-segment code decoder.
module hex_to_seg
  import digital_tube_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/digital_tube_ctrl.sv
// Bus-mapped controller that time-multiplexes a 32-bit DATA word and a CTRL
// nibble onto two four-digit tube groups and one single-digit tube.
module digital_tube_ctrl
  import digital_tube_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        addr,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  digital_tube0,
  output logic [3:0]  digital_tube_sel0,
  output logic [7:0]  digital_tube1,
  output logic [3:0]  digital_tube_sel1,
  output logic [7:0]  digital_tube2,
  output logic        digital_tube_sel2
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [31:0]       data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  tube_out_t         out_q, out_d;

  logic       enable_s;
  logic [3:0] digit0_s, digit1_s;
  logic [7:0] seg0_s, seg1_s, seg2_s;

  assign enable_s = ctrl_q[CTRL_EN_BIT];

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (we && (addr == DATA_ADDR)) begin
      data_d = merge_bytes(data_q, wdata, byte_en);
    end else if (we && (addr == CTRL_ADDR) && byte_en[0]) begin
      ctrl_d = wdata[CTRL_W-1:0];
    end else begin
      data_d = data_q;
      ctrl_d = ctrl_q;
    end
  end

  always_comb begin
    if (addr == CTRL_ADDR) begin
      rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
    end else begin
      rdata = data_q;
    end
  end

  // Scan is parked at slot 0 while disabled so re-enabling restarts at digit 0.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!enable_s) begin
      cnt_d = '0;
      idx_d = 2'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
  end

  always_comb begin
    digit0_s = 4'h0;
    digit1_s = 4'h0;
    case (idx_q)
      2'd0: begin
        digit0_s = data_q[3:0];
        digit1_s = data_q[19:16];
      end
      2'd1: begin
        digit0_s = data_q[7:4];
        digit1_s = data_q[23:20];
      end
      2'd2: begin
        digit0_s = data_q[11:8];
        digit1_s = data_q[27:24];
      end
      2'd3: begin
        digit0_s = data_q[15:12];
        digit1_s = data_q[31:28];
      end
      default: begin
        digit0_s = 4'h0;
        digit1_s = 4'h0;
      end
    endcase
  end

  hex_to_seg u_seg0 (.hex(digit0_s), .seg(seg0_s));
  hex_to_seg u_seg1 (.hex(digit1_s), .seg(seg1_s));
  hex_to_seg u_seg2 (.hex(ctrl_q[CTRL_VAL_MSB:CTRL_VAL_LSB]), .seg(seg2_s));

  always_comb begin
    out_d = TUBE_OUT_BLANK;
    if (enable_s) begin
      out_d.seg0 = seg0_s;
      out_d.sel0 = digit_sel_n(idx_q);
      out_d.seg1 = seg1_s;
      out_d.sel1 = digit_sel_n(idx_q);
      out_d.seg2 = seg2_s;
      out_d.sel2 = 1'b0;
    end else begin
      out_d = TUBE_OUT_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= 32'h0000_0000;
      ctrl_q <= CTRL_RESET;
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      out_q  <= TUBE_OUT_BLANK;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      out_q  <= out_d;
    end
  end

  assign digital_tube0     = out_q.seg0;
  assign digital_tube_sel0 = out_q.sel0;
  assign digital_tube1     = out_q.seg1;
  assign digital_tube_sel1 = out_q.sel1;
  assign digital_tube2     = out_q.seg2;
  assign digital_tube_sel2 = out_q.sel2;

endmodule

// File: tb/tb_digital_tube_ctrl.sv
// Self-checking bench: cycle-level reference model plus directed hand-checked points.
module tb_digital_tube_ctrl;

  localparam int SD = 4;
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  localparam logic [3:0] SEL_LUT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic        clk = 1'b0;
  logic        reset, we, addr;
  logic [3:0]  byte_en;
  logic [31:0] wdata, rdata;
  logic [7:0]  digital_tube0, digital_tube1, digital_tube2;
  logic [3:0]  digital_tube_sel0, digital_tube_sel1;
  logic        digital_tube_sel2;

  int checks = 0;
  int failures = 0;

  digital_tube_ctrl #(.SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .byte_en(byte_en),
    .wdata(wdata), .rdata(rdata),
    .digital_tube0(digital_tube0), .digital_tube_sel0(digital_tube_sel0),
    .digital_tube1(digital_tube1), .digital_tube_sel1(digital_tube_sel1),
    .digital_tube2(digital_tube2), .digital_tube_sel2(digital_tube_sel2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: t = enabled cycles since the scan (re)started.
  logic [31:0] m_data;
  logic [4:0]  m_ctrl;
  int          m_t;
  bit          m_valid = 1'b0;
  logic [7:0]  e_t0, e_t1, e_t2;
  logic [3:0]  e_s0, e_s1;
  logic        e_s2;

  function automatic logic [7:0] exp_seg(input logic [31:0] d, input logic [4:0] c,
                                         input int t, input int g);
    int k;
    if (!c[4]) return 8'hFF;
    k = (t / SD) % 4;
    return SEG_LUT[d[16*g + 4*k +: 4]];
  endfunction

  function automatic logic [3:0] exp_sel(input logic [4:0] c, input int t);
    if (!c[4]) return 4'hF;
    return SEL_LUT[(t / SD) % 4];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] d, input logic [31:0] w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = d;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (reset) begin
      e_t0 <= 8'hFF; e_t1 <= 8'hFF; e_t2 <= 8'hFF;
      e_s0 <= 4'hF;  e_s1 <= 4'hF;  e_s2 <= 1'b1;
      m_data <= 32'h0; m_ctrl <= 5'h10; m_t <= 0;
    end else begin
      e_t0 <= exp_seg(m_data, m_ctrl, m_t, 0);
      e_t1 <= exp_seg(m_data, m_ctrl, m_t, 1);
      e_s0 <= exp_sel(m_ctrl, m_t);
      e_s1 <= exp_sel(m_ctrl, m_t);
      e_t2 <= m_ctrl[4] ? SEG_LUT[m_ctrl[3:0]] : 8'hFF;
      e_s2 <= !m_ctrl[4];
      m_t  <= m_ctrl[4] ? m_t + 1 : 0;
      if (we && !addr) m_data <= merge(m_data, wdata, byte_en);
      if (we && addr && byte_en[0]) m_ctrl <= wdata[4:0];
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_tube0", 32'(digital_tube0), 32'(e_t0));
      chk("m_sel0",  32'(digital_tube_sel0), 32'(e_s0));
      chk("m_tube1", 32'(digital_tube1), 32'(e_t1));
      chk("m_sel1",  32'(digital_tube_sel1), 32'(e_s1));
      chk("m_tube2", 32'(digital_tube2), 32'(e_t2));
      chk("m_sel2",  32'(digital_tube_sel2), 32'(e_s2));
      chk("m_rdata", rdata, addr ? {27'd0, m_ctrl} : m_data);
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic a, input logic [3:0] be, input logic [31:0] d);
    we = 1'b1; addr = a; byte_en = be; wdata = d;
    @(posedge clk); #1;
    we = 1'b0; byte_en = 4'h0;
  endtask

  task automatic chk_blank(input string name);
    chk(name, {digital_tube0, digital_tube1, digital_tube2, digital_tube_sel0,
               digital_tube_sel1[2:0], digital_tube_sel2}, 32'hFFFF_FFFF);
  endtask

  localparam logic [7:0] G0 [4] = '{8'hA1, 8'hC6, 8'h83, 8'h88};
  localparam logic [7:0] G1 [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};

  initial begin
    reset = 1'b1; we = 1'b0; addr = 1'b0; byte_en = 4'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_blank("rst_blank");
    chk("rst_rdata", rdata, 32'h0);

    sync(); reset = 1'b0; addr = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rel_tube0", 32'(digital_tube0), 32'hC0);
    chk("rel_tube1", 32'(digital_tube1), 32'hC0);
    chk("rel_sel0",  32'(digital_tube_sel0), 32'hE);
    chk("rel_sel1",  32'(digital_tube_sel1), 32'hE);
    chk("rel_tube2", 32'(digital_tube2), 32'hC0);
    chk("rel_sel2",  32'(digital_tube_sel2), 32'h0);
    chk("rel_ctrl",  rdata, 32'h10);

    // Aligned scan of 0x3210_ABCD, started by re-enabling.
    sync();
    wr(1'b1, 4'hF, 32'h0);
    wr(1'b0, 4'hF, 32'h3210_ABCD);
    wr(1'b1, 4'hF, 32'h10);
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("scan_tube0", 32'(digital_tube0), 32'(G0[i/4]));
      chk("scan_tube1", 32'(digital_tube1), 32'(G1[i/4]));
      chk("scan_sel0",  32'(digital_tube_sel0), 32'(SEL_LUT[i/4]));
    end

    sync();
    wr(1'b1, 4'hF, 32'h0);
    @(posedge clk); @(negedge clk);
    chk_blank("dis_blank");

    sync();
    wr(1'b0, 4'hF, 32'h0);
    wr(1'b0, 4'b0010, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("be_rdata", rdata, 32'h0000_FF00);
    sync();
    wr(1'b0, 4'h0, 32'h1234_5678);
    @(negedge clk);
    chk("be0_rdata", rdata, 32'h0000_FF00);

    sync();
    wr(1'b1, 4'hF, 32'h15);
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("be_tube0", 32'(digital_tube0), (i >= 8) ? 32'h8E : 32'hC0);
      chk("be_tube1", 32'(digital_tube1), 32'hC0);
      chk("ctrl5_tube2", 32'(digital_tube2), 32'h92);
    end

    sync();
    wr(1'b1, 4'b1110, 32'h0);
    @(negedge clk);
    chk("ctrl_be_rdata", rdata, 32'h15);

    sync();
    for (int v = 0; v < 16; v++) wr(1'b1, 4'hF, 32'h10 | 32'(v));
    @(posedge clk); @(negedge clk);
    chk("sweep_tube2", 32'(digital_tube2), 32'h8E);

    // Reset with counter=2, idx=2.
    sync();
    wr(1'b1, 4'hF, 32'h0);
    wr(1'b1, 4'hF, 32'h10);
    repeat (10) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_blank("midrst_blank");
    sync(); reset = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_sel0", 32'(digital_tube_sel0), (i < 4) ? 32'hE : 32'hD);
    end

    // DATA write on the wrap edge.
    sync();
    wr(1'b1, 4'hF, 32'h0);
    wr(1'b1, 4'hF, 32'h10);
    repeat (3) @(posedge clk);
    #1;
    wr(1'b0, 4'hF, 32'h0000_0050);
    @(negedge clk);
    chk("wrap_tube0_a", 32'(digital_tube0), 32'hC0);
    chk("wrap_sel0_a",  32'(digital_tube_sel0), 32'hE);
    @(negedge clk);
    chk("wrap_tube0_b", 32'(digital_tube0), 32'h92);
    chk("wrap_sel0_b",  32'(digital_tube_sel0), 32'hD);
    repeat (3) @(negedge clk);
    chk("wrap_sel0_c",  32'(digital_tube_sel0), 32'hD);
    @(negedge clk);
    chk("wrap_sel0_d",  32'(digital_tube_sel0), 32'hB);
    chk("wrap_tube0_d", 32'(digital_tube0), 32'hC0);

    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
